// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock flexible FIFO.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int f_ptr_w(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, combinational read address into a
// registered read port with optional write-first bypass on address collision.
module sync_fifo_mem #(
    parameter int G_WIDTH    = 8,
    parameter int G_DEPTH    = 4,
    parameter bit G_WR_FIRST = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [G_DEPTH-1:0] wr_addr_i,
    input  logic [G_WIDTH-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [G_DEPTH-1:0] rd_addr_i,
    output logic [G_WIDTH-1:0] rd_data_o
);

    logic [G_WIDTH-1:0] mem_q [2**G_DEPTH];
    logic [G_WIDTH-1:0] rd_data_q;
    logic               bypass;

    assign bypass = G_WR_FIRST && wr_en_i && (wr_addr_i == rd_addr_i);

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= bypass ? wr_data_i : mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int G_WIDTH  = 8,
    parameter int G_DEPTH  = 4,
    parameter int G_FWFT   = 0,
    parameter int G_AFULL  = (2**G_DEPTH) - 2,
    parameter int G_AEMPTY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [G_WIDTH-1:0] i_data,
    input  logic               i_rd,
    input  logic               i_clr_err,
    output logic [G_WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic [G_DEPTH:0]   o_fill_level,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               o_overflow_sticky,
    output logic               o_underflow_sticky
);

    localparam int            PW       = f_ptr_w(G_DEPTH);
    localparam int            CAP      = 2**G_DEPTH;
    localparam fifo_mode_e    MODE     = (G_FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PW-1:0] FILL_MAX = PW'(CAP);
    localparam logic [PW-1:0] AF_LVL   = PW'(G_AFULL);
    localparam logic [PW-1:0] AE_LVL   = PW'(G_AEMPTY);

    if (G_AFULL < 1 || G_AFULL > CAP) begin : g_bad_afull
        $error("sync_fifo_flex: G_AFULL=%0d outside 1..%0d", G_AFULL, CAP);
    end
    if (G_AEMPTY < 0 || G_AEMPTY > CAP - 1) begin : g_bad_aempty
        $error("sync_fifo_flex: G_AEMPTY=%0d outside 0..%0d", G_AEMPTY, CAP - 1);
    end

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] fill_q, fill_d;
    logic          valid_q, valid_d;
    logic          full_q, empty_q, afull_q, aempty_q;
    fifo_err_t     err_now, sticky_q, sticky_d;
    logic          wr_acc, rd_acc, mem_rd_en;

    always_comb begin
        rd_acc = (MODE == FIFO_FWFT) ? (i_rd && valid_q) : (i_rd && !empty_q);
        wr_acc = i_wr && (!full_q || rd_acc);
        if (MODE == FIFO_FWFT) begin
            // Head register refills whenever it is free or being consumed; an
            // empty RAM hands the incoming word straight through (write-first).
            mem_rd_en = (!valid_q || rd_acc) && ((wr_ptr_q != rd_ptr_q) || wr_acc);
            valid_d   = mem_rd_en || (valid_q && !rd_acc);
        end else begin
            mem_rd_en = rd_acc;
            valid_d   = rd_acc;
        end
        fill_d             = fill_q + PW'(wr_acc) - PW'(rd_acc);
        err_now.overflow   = i_wr && !wr_acc;
        err_now.underflow  = i_rd && !rd_acc;
        sticky_d.overflow  = err_now.overflow  || (sticky_q.overflow  && !i_clr_err);
        sticky_d.underflow = err_now.underflow || (sticky_q.underflow && !i_clr_err);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            sticky_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (mem_rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            fill_q   <= fill_d;
            valid_q  <= valid_d;
            full_q   <= (fill_d == FILL_MAX);
            empty_q  <= (fill_d == '0);
            afull_q  <= (fill_d >= AF_LVL);
            aempty_q <= (fill_d <= AE_LVL);
            sticky_q <= sticky_d;
        end
    end

    sync_fifo_mem #(
        .G_WIDTH    (G_WIDTH),
        .G_DEPTH    (G_DEPTH),
        .G_WR_FIRST (MODE == FIFO_FWFT)
    ) u_mem (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[G_DEPTH-1:0]),
        .wr_data_i (i_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (rd_ptr_q[G_DEPTH-1:0]),
        .rd_data_o (o_data)
    );

    assign o_valid            = valid_q;
    assign o_fill_level       = fill_q;
    assign o_full             = full_q;
    assign o_empty            = empty_q;
    assign o_almost_full      = afull_q;
    assign o_almost_empty     = aempty_q;
    assign o_overflow         = err_now.overflow;
    assign o_underflow        = err_now.underflow;
    assign o_overflow_sticky  = sticky_q.overflow;
    assign o_underflow_sticky = sticky_q.underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: standard and FWFT instances share stimulus and are
// compared against a queue-based reference plus a table of fixed expectations.
module tb_sync_fifo_flex;

    localparam int W   = 8;
    localparam int D   = 3;
    localparam int CAP = 8;
    localparam int AF  = 6;
    localparam int AE  = 1;

    logic         clk = 1'b0;
    logic         rst, wr, rd, clr;
    logic [W-1:0] din;

    logic [W-1:0] s_data, f_data;
    logic [D:0]   s_fill, f_fill;
    logic s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_ovs, s_uds;
    logic f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_ovs, f_uds;

    always #5 clk = ~clk;

    sync_fifo_flex #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(0), .G_AFULL(AF), .G_AEMPTY(AE)) u_std (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd), .i_clr_err(clr),
        .o_data(s_data), .o_valid(s_valid), .o_fill_level(s_fill), .o_full(s_full),
        .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
        .o_overflow(s_ovf), .o_underflow(s_udf),
        .o_overflow_sticky(s_ovs), .o_underflow_sticky(s_uds)
    );

    sync_fifo_flex #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(1), .G_AFULL(AF), .G_AEMPTY(AE)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd), .i_clr_err(clr),
        .o_data(f_data), .o_valid(f_valid), .o_fill_level(f_fill), .o_full(f_full),
        .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
        .o_overflow(f_ovf), .o_underflow(f_udf),
        .o_overflow_sticky(f_ovs), .o_underflow_sticky(f_uds)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: contents as a queue, plus what a standard-mode reader last saw.
    logic [W-1:0] mq[$];
    logic         m_ovs, m_uds, m_sval;
    logic [W-1:0] m_sdata;
    logic         smp_ovf_s, smp_udf_s, smp_ovf_f, smp_udf_f;

    typedef struct {
        logic w, r, c;
        logic [W-1:0] d;
        int   fill;
        logic full, af, ae, ovf, udf, ovs, uds;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic w, r, c, input logic [W-1:0] d, input int fill,
                                input logic full, af, ae, ovf, udf, ovs, uds);
        vec_t v;
        v.w = w; v.r = r; v.c = c; v.d = d; v.fill = fill;
        v.full = full; v.af = af; v.ae = ae; v.ovf = ovf; v.udf = udf; v.ovs = ovs; v.uds = uds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("std.fill",  32'(s_fill), n);
        chk("std.full",  32'(s_full), 32'(n == CAP));
        chk("std.empty", 32'(s_empty), 32'(n == 0));
        chk("std.afull", 32'(s_af), 32'(n >= AF));
        chk("std.aempty", 32'(s_ae), 32'(n <= AE));
        chk("std.ovf_sticky", 32'(s_ovs), 32'(m_ovs));
        chk("std.udf_sticky", 32'(s_uds), 32'(m_uds));
        chk("std.valid", 32'(s_valid), 32'(m_sval));
        chk("std.data",  32'(s_data), 32'(m_sdata));
        chk("fwft.fill", 32'(f_fill), n);
        chk("fwft.full", 32'(f_full), 32'(n == CAP));
        chk("fwft.empty", 32'(f_empty), 32'(n == 0));
        chk("fwft.afull", 32'(f_af), 32'(n >= AF));
        chk("fwft.aempty", 32'(f_ae), 32'(n <= AE));
        chk("fwft.ovf_sticky", 32'(f_ovs), 32'(m_ovs));
        chk("fwft.udf_sticky", 32'(f_uds), 32'(m_uds));
        chk("fwft.valid", 32'(f_valid), 32'(n != 0));
        if (n != 0) chk("fwft.head", 32'(f_data), 32'(mq[0]));
    endtask

    task automatic step(input logic w, r, c, input logic [W-1:0] d);
        logic ra, wa, eo, eu;
        wr = w; rd = r; clr = c; din = d; rst = 1'b0;
        @(negedge clk);
        smp_ovf_s = s_ovf; smp_udf_s = s_udf; smp_ovf_f = f_ovf; smp_udf_f = f_udf;
        ra = r && (mq.size() > 0);
        wa = w && ((mq.size() < CAP) || ra);
        eo = w && !wa;
        eu = r && !ra;
        chk("std.overflow",  32'(smp_ovf_s), 32'(eo));
        chk("std.underflow", 32'(smp_udf_s), 32'(eu));
        chk("fwft.overflow", 32'(smp_ovf_f), 32'(eo));
        chk("fwft.underflow", 32'(smp_udf_f), 32'(eu));
        m_sval = ra;
        if (ra) m_sdata = mq.pop_front();
        if (wa) mq.push_back(d);
        m_ovs = eo || (m_ovs && !c);
        m_uds = eu || (m_uds && !c);
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic do_reset(input logic w, r, input logic [W-1:0] d);
        wr = w; rd = r; clr = 1'b0; din = d; rst = 1'b1;
        @(negedge clk);
        mq.delete();
        m_ovs = 1'b0; m_uds = 1'b0; m_sval = 1'b0; m_sdata = '0;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        check_state();
    endtask

    initial begin
        logic [W-1:0] e;
        int rv;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;

        // w r c data fill full af ae ovf udf ovs uds
        tbl.push_back(mk(1,0,0,8'h01, 1,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h02, 2,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h03, 3,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h04, 4,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h05, 5,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h06, 6,0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h07, 7,0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h08, 8,1,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h09, 8,1,1,0, 1,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 7,0,1,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 6,0,1,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 5,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 4,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 3,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 2,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 1,0,0,1, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 0,0,0,1, 0,0,1,0));
        tbl.push_back(mk(0,1,0,8'h00, 0,0,0,1, 0,1,1,1));
        tbl.push_back(mk(0,0,1,8'h00, 0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,0,0,1, 0,1,0,1));
        tbl.push_back(mk(0,0,1,8'h00, 0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,1,0,8'h11, 1,0,0,1, 0,1,0,1));
        tbl.push_back(mk(0,1,1,8'h00, 0,0,0,1, 0,0,0,0));

        do_reset(1'b0, 1'b0, '0);
        chk("rst.std.data", 32'(s_data), 32'h0);
        chk("rst.fwft.data", 32'(f_data), 32'h0);
        chk("rst.std.valid", 32'(s_valid), 32'h0);
        chk("rst.fwft.valid", 32'(f_valid), 32'h0);
        chk("rst.aempty", 32'(s_ae), 32'h1);
        chk("rst.afull", 32'(s_af), 32'h0);

        // Fill/overflow, drain/underflow, clear and set-beats-clear sequence
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d.std.fill", i), 32'(s_fill), tbl[i].fill);
            chk($sformatf("tbl%0d.fwft.fill", i), 32'(f_fill), tbl[i].fill);
            chk($sformatf("tbl%0d.full", i), 32'(s_full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d.afull", i), 32'(f_af), 32'(tbl[i].af));
            chk($sformatf("tbl%0d.aempty", i), 32'(s_ae), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d.ovf", i), 32'(smp_ovf_s), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.udf", i), 32'(smp_udf_f), 32'(tbl[i].udf));
            chk($sformatf("tbl%0d.ovs", i), 32'(f_ovs), 32'(tbl[i].ovs));
            chk($sformatf("tbl%0d.uds", i), 32'(s_uds), 32'(tbl[i].uds));
        end

        // Push+pop at full: both accepted, new word comes out eighth
        do_reset(1'b0, 1'b0, '0);
        for (int i = 1; i <= CAP; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        chk("full.fwft.head", 32'(f_data), 32'h01);
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("full.pushpop.ovf", 32'(smp_ovf_s), 32'h0);
        chk("full.pushpop.fill", 32'(s_fill), 32'd8);
        chk("full.pushpop.std.data", 32'(s_data), 32'h01);
        chk("full.pushpop.fwft.head", 32'(f_data), 32'h02);
        for (int k = 1; k <= CAP; k++) begin
            if (k == CAP) chk("full.a5.fwft.head", 32'(f_data), 32'hA5);
            step(1'b0, 1'b1, 1'b0, '0);
            if (k == CAP) chk("full.a5.std.data", 32'(s_data), 32'hA5);
        end

        // Latency: FWFT fall-through and standard one-cycle read
        do_reset(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("lat.fwft.valid", 32'(f_valid), 32'h1);
        chk("lat.fwft.data", 32'(f_data), 32'h3C);
        chk("lat.std.valid_before", 32'(s_valid), 32'h0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("lat.std.valid", 32'(s_valid), 32'h1);
        chk("lat.std.data", 32'(s_data), 32'h3C);
        chk("lat.fwft.drop", 32'(f_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("lat.std.pulse", 32'(s_valid), 32'h0);
        chk("lat.std.hold", 32'(s_data), 32'h3C);
        step(1'b1, 1'b0, 1'b0, 8'h40);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'(8'h41 + k));
            e = 8'(8'h40 + k);
            chk("stream.std.data", 32'(s_data), 32'(e));
            chk("stream.fwft.head", 32'(f_data), 32'(e + 8'h01));
        end

        // Long run around fill 4 so pointers wrap several times
        do_reset(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 4) step(1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
            else step(1'b1, 1'b1, 1'b0, 8'($urandom));
        end

        // Reset in the middle of a burst
        do_reset(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
        do_reset(1'b1, 1'b1, 8'hEE);
        chk("midrst.fill", 32'(s_fill), 32'h0);
        chk("midrst.empty", 32'(f_empty), 32'h1);
        chk("midrst.fwft.valid", 32'(f_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        step(1'b1, 1'b1, 1'b0, 8'h5B);
        chk("midrst.first", 32'(s_data), 32'h5A);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("midrst.second", 32'(s_data), 32'h5B);

        // Randomized traffic with occasional clears and resets
        for (int k = 0; k < 400; k++) begin
            rv = int'($urandom_range(0, 99));
            if (rv < 2) do_reset(1'($urandom), 1'($urandom), 8'($urandom));
            else step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                      1'($urandom_range(0, 99) < 6), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
